// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and its fairness counter.
package dmem_pkg;

    localparam int unsigned DMEM_DW = 16;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    typedef enum logic {
        CORE_PRI  = 1'b0,
        HOST_TURN = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_fair_ctr.sv
// Host-starvation bound: after MAX_HOLD consecutive core grants with the host waiting,
// the host gets priority for exactly one grant. Used only with DMEM_ARB_FAIRNESS_EN.
module arb_fair_ctr
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic core_gnt_i,
    input  logic host_gnt_i,
    input  logic host_req_i,
    output logic host_pri_o
);

    localparam logic [7:0] HoldLim = 8'(MAX_HOLD);

    arb_state_e state_q;
    logic [7:0] cnt_q;
    logic       host_pri_q;
    logic [7:0] cnt_inc;

    assign cnt_inc    = cnt_q + 8'd1;
    assign host_pri_o = host_pri_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CORE_PRI;
            cnt_q      <= '0;
            host_pri_q <= 1'b0;
        end else begin
            case (state_q)
                CORE_PRI: begin
                    if (!host_req_i || host_gnt_i) begin
                        cnt_q <= '0;
                    end else if (core_gnt_i) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == HoldLim) begin
                            state_q    <= HOST_TURN;
                            host_pri_q <= 1'b1;
                        end
                    end
                end
                HOST_TURN: begin
                    // Leave on the host grant, or when the host withdraws.
                    if (!host_req_i || host_gnt_i) begin
                        state_q    <= CORE_PRI;
                        host_pri_q <= 1'b0;
                        cnt_q      <= '0;
                    end
                end
                default: begin
                    state_q    <= CORE_PRI;
                    host_pri_q <= 1'b0;
                    cnt_q      <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single-port synchronous-read data RAM. Strict core priority;
// define DMEM_ARB_FAIRNESS_EN to bound host starvation via arb_fair_ctr.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned AW       = 12,
    parameter int unsigned DW       = DMEM_DW,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wdata_i,
    output logic          core_gnt_o,
    output logic          core_rvalid_o,
    output logic [DW-1:0] core_rdata_o,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_wdata_i,
    output logic          host_gnt_o,
    output logic          host_rvalid_o,
    output logic [DW-1:0] host_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("dmem_arbiter: MAX_HOLD must be in 1..255");
    end

    logic   host_pri;
    owner_e owner_q, owner_d;
    logic   rd_q, rd_d;

`ifdef DMEM_ARB_FAIRNESS_EN
    arb_fair_ctr #(
        .MAX_HOLD (MAX_HOLD)
    ) u_fair_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_gnt_i (core_gnt_o),
        .host_gnt_i (host_gnt_o),
        .host_req_i (host_req_i),
        .host_pri_o (host_pri)
    );
`else
    assign host_pri = 1'b0;
`endif

    always_comb begin
        // A withdrawn host request never blocks the core, even during the host's turn.
        core_gnt_o  = core_req_i & ~(host_pri & host_req_i);
        host_gnt_o  = host_req_i & ~core_gnt_o;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        owner_d     = owner_q;
        rd_d        = 1'b0;
        if (core_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = core_we_i;
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
            if (!core_we_i) begin
                owner_d = OWN_CORE;
                rd_d    = 1'b1;
            end
        end else if (host_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = host_we_i;
            mem_addr_o  = host_addr_i;
            mem_wdata_o = host_wdata_i;
            if (!host_we_i) begin
                owner_d = OWN_HOST;
                rd_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_CORE;
            rd_q    <= 1'b0;
        end else begin
            owner_q <= owner_d;
            rd_q    <= rd_d;
        end
    end

    assign core_rvalid_o = rd_q && (owner_q == OWN_CORE);
    assign host_rvalid_o = rd_q && (owner_q == OWN_HOST);
    assign core_rdata_o  = mem_rdata_i;
    assign host_rdata_o  = mem_rdata_i;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single-port 16-bit data memory between the processor core and the host loader/unloader (matrix operand load, result dump). It sits between the core's memory port, the host port and the synchronous-read data RAM. It issues same-cycle grants, routes 1-cycle-latency read data back to the requester that issued the read, and optionally bounds host starvation.

## Interface
- AW, default 12: memory word address width.
- DW, default 16: data width; matches the core's memory bus.
- MAX_HOLD, default 8: maximum number of consecutive core grants while host is waiting (fairness build only); legal range 1..255.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- core_req, core_we  in  1  core request and write enable.
- core_addr  in  AW  core address.
- core_wdata  in  DW  core write data.
- core_gnt  out  1  core request accepted this cycle.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DW  core read data.
- host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata: same as the core_* ports, for the host port.
- mem_en, mem_we  out  1  RAM enable and write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid 1 cycle after mem_en with mem_we=0.

## Operation
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt=1 in the same cycle.
  - A transfer occurs on a clock edge where req && gnt.
  - Deasserting req before the grant is legal; the request is simply withdrawn.
- Arbitration is combinational from req and the registered state. At most one gnt is high per cycle.
- The granted port's we/addr/wdata drive the mem_* outputs.
- When there is no grant: mem_en=0, mem_we=0, and mem_addr/mem_wdata are 0.
- Base policy (strict priority):
  - The core wins whenever core_req=1.
  - The host is granted only when core_req=0.
- Read return:
  - A registered owner tag and read flag are captured on every granted read.
  - On the next cycle, exactly that port's rvalid=1.
  - Both rdata outputs always carry mem_rdata; rvalid qualifies them.
  - Writes produce no rvalid.
- Back-to-back reads are fully pipelined: one grant per cycle.
- Reads and writes of different ports may interleave freely. RAM ordering is the only ordering.

## Timing
- Grant latency is 0 cycles (gnt is in the same cycle as req, when the request wins).
- Read data latency is exactly 1 cycle after the grant edge.
- Write takes effect at the grant edge.
- Reset values: core_rvalid=0, host_rvalid=0, owner tag=core, read flag=0, hold counter=0, FSM=CORE_PRI.
- Reset mid-operation:
  - An in-flight read's rvalid is dropped (not delivered after reset release).
  - mem_en follows the combinational rule immediately, with no stale grant.
- Simultaneous requests are resolved by the policy; ties never produce two grants.

## Configuration
- Macro: DMEM_ARB_FAIRNESS_EN.
- Without the macro: strict core priority as above. No counter or FSM is synthesized. The host may starve indefinitely.
- With the macro, a two-state FSM bounds host starvation:
  - CORE_PRI: the core has priority.
    - The hold counter increments on each core grant while host_req=1.
    - The counter clears when host_req=0 or on a host grant.
    - When the counter reaches MAX_HOLD and host_req=1, the FSM goes to HOST_TURN.
  - HOST_TURN: the host has priority for exactly one grant.
    - On the host grant, the FSM returns to CORE_PRI and the counter clears.
    - If host_req drops while in HOST_TURN, the FSM returns to CORE_PRI without a grant; the core may be granted in that cycle.
- The worst-case host wait is MAX_HOLD cycles of continuous core requests.

## Structure
- Shared package `dmem_pkg`:
  - Owner enum (OWN_CORE, OWN_HOST).
  - Arbiter FSM state enum (CORE_PRI, HOST_TURN).
  - DW default constant, shared with the processor.
- The 2:1 request mux is inline; there is no sub-module.
- The optional fairness logic is a natural sub-module, `arb_fair_ctr`. It takes core_gnt, host_gnt and host_req, and outputs host_pri.

## Test plan
- Reset: hold rst_n=0 with both requesters requesting → gnt outputs ignored, rvalid=0, mem_we=0 on release edge; first cycle after release core_gnt=1.
- Host-only load: host writes 0x1234 to addr 0x005, then reads addr 0x005 → host_gnt=1 each cycle; host_rvalid=1 exactly one cycle after the read grant with host_rdata=0x1234; core_rvalid stays 0.
- Contention, strict build: core and host request continuously for 20 cycles → core_gnt=1 all 20 cycles, host_gnt=0; the host is granted in the first cycle core_req drops.
- Contention, DMEM_ARB_FAIRNESS_EN, MAX_HOLD=8 → grants repeat as 8 core, 1 host; host_rvalid is tagged correctly for host reads.
- Interleaved reads: core reads 0x010 (data 0xAAAA) and the host reads 0x011 (0x5555) in consecutive grant cycles → core_rvalid then host_rvalid on consecutive cycles, with correct data and never both high.
- Reset mid-read: assert rst_n=0 in the cycle after a core read grant → core_rvalid=0 throughout reset and after release, with no spurious rvalid.
